// File: rtl/tcp_pkg.sv
// Shared TCP connection types: state encoding, header flag bit positions and
// helpers that decode a state into its send-request fields.
package tcp_pkg;

  localparam int FLAG_W = 8;

  localparam int FIN_B = 0;
  localparam int SYN_B = 1;
  localparam int RST_B = 2;
  localparam int PSH_B = 3;
  localparam int ACK_B = 4;
  localparam int URG_B = 5;
  localparam int ECE_B = 6;
  localparam int CWR_B = 7;

  typedef enum logic [3:0] {
    CLOSED     = 4'd0,
    SYN_EMIT   = 4'd1,
    SYN_SENT   = 4'd2,
    ACK_EMIT   = 4'd3,
    EST        = 4'd4,
    FIN1_EMIT  = 4'd5,
    FIN_WAIT_1 = 4'd6,
    FIN_WAIT_2 = 4'd7,
    TW_EMIT    = 4'd8,
    TIME_WAIT  = 4'd9,
    CW_EMIT    = 4'd10,
    CLOSE_WAIT = 4'd11,
    LA_EMIT    = 4'd12,
    LAST_ACK   = 4'd13
  } tcp_state_e;

  // EST only asks to send when a received segment still owes an ACK.
  function automatic logic req_v_f(tcp_state_e st, logic ack_pend);
    case (st)
      SYN_EMIT, ACK_EMIT, FIN1_EMIT, TW_EMIT, CW_EMIT, LA_EMIT: req_v_f = 1'b1;
      EST:     req_v_f = ack_pend;
      default: req_v_f = 1'b0;
    endcase
  endfunction

  function automatic logic [FLAG_W-1:0] req_flag_f(tcp_state_e st, logic ack_pend);
    logic [FLAG_W-1:0] f;
    f = '0;
    case (st)
      SYN_EMIT:                  f[SYN_B] = 1'b1;
      FIN1_EMIT, LA_EMIT:        begin f[FIN_B] = 1'b1; f[ACK_B] = 1'b1; end
      ACK_EMIT, TW_EMIT, CW_EMIT: f[ACK_B] = 1'b1;
      EST:                       f[ACK_B] = ack_pend;
      default:                   f = '0;
    endcase
    return f;
  endfunction

  function automatic logic is_rto_state(tcp_state_e st);
    return (st == SYN_SENT) || (st == FIN_WAIT_1) || (st == LAST_ACK);
  endfunction

endpackage

// File: rtl/tcp_conn_fsm_if.sv
// Bundle of the connection FSM's event inputs and send-request/status outputs.
// valid/ready: req_v stays high with stable fields until sent_v is seen; sent_v
// is only meaningful while req_v is high and completes exactly one request.
interface tcp_conn_fsm_if #(
  parameter int SEQ_W  = 32,
  parameter int SIZE_W = 16
);
  import tcp_pkg::*;

  logic              open_v;
  logic [SEQ_W-1:0]  open_seq;
  logic              close_v;
  logic              cancel_v;
  logic              rec_v;
  logic [SIZE_W-1:0] rec_size;
  logic [SEQ_W-1:0]  rec_seq;
  logic [SEQ_W-1:0]  rec_ack;
  logic [FLAG_W-1:0] rec_flag;
  logic              sent_v;
  logic [SIZE_W-1:0] send_size;
  logic              req_v;
  logic [FLAG_W-1:0] req_flag;
  logic [SEQ_W-1:0]  req_seq;
  logic [SEQ_W-1:0]  req_ack;
  logic              valid;
  logic              est;
  logic [3:0]        state;

  modport master (
    output open_v, open_seq, close_v, cancel_v, rec_v, rec_size, rec_seq,
           rec_ack, rec_flag, sent_v, send_size,
    input  req_v, req_flag, req_seq, req_ack, valid, est, state
  );

  modport slave (
    input  open_v, open_seq, close_v, cancel_v, rec_v, rec_size, rec_seq,
           rec_ack, rec_flag, sent_v, send_size,
    output req_v, req_flag, req_seq, req_ack, valid, est, state
  );

endinterface

// File: rtl/tcp_timer.sv
// Load/expire down-counter: expire_o is high in the MAX-th cycle after load_i,
// so a state that loads on entry leaves after exactly MAX cycles.
module tcp_timer #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic expire_o
);
  localparam int W = $clog2(MAX) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = W'(MAX);
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/tcp_conn_fsm.sv
// Single-connection TCP state machine (active/passive open and close).
// Define TCP_RETX_EN to add SYN/FIN retransmission after RTO_CYCLES.
module tcp_conn_fsm
  import tcp_pkg::*;
#(
  parameter int SEQ_W      = 32,
  parameter int SIZE_W     = 16,
  parameter int TW_CYCLES  = 1024,
  parameter int RTO_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              open_v_i,
  input  logic [SEQ_W-1:0]  open_seq_i,
  input  logic              close_v_i,
  input  logic              cancel_v_i,
  input  logic              rec_v_i,
  input  logic [SIZE_W-1:0] rec_size_i,
  input  logic [SEQ_W-1:0]  rec_seq_i,
  input  logic [SEQ_W-1:0]  rec_ack_i,
  input  logic [FLAG_W-1:0] rec_flag_i,
  input  logic              sent_v_i,
  input  logic [SIZE_W-1:0] send_size_i,
  output logic              req_v_o,
  output logic [FLAG_W-1:0] req_flag_o,
  output logic [SEQ_W-1:0]  req_seq_o,
  output logic [SEQ_W-1:0]  req_ack_o,
  output logic              valid_o,
  output logic              est_o,
  output logic [3:0]        state_o
);
  tcp_state_e        state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d, ack_q, ack_d;
  logic              pend_q, pend_d;
  logic              req_v_q, valid_q, est_q;
  logic [FLAG_W-1:0] req_flag_q;
  logic              tw_exp, rto_exp;
  logic              rec_syn, rec_ack, rec_fin, rec_rst, ack_ok;

  assign rec_syn = rec_v_i & rec_flag_i[SYN_B];
  assign rec_ack = rec_v_i & rec_flag_i[ACK_B];
  assign rec_fin = rec_v_i & rec_flag_i[FIN_B];
  assign rec_rst = rec_v_i & rec_flag_i[RST_B];
  assign ack_ok  = rec_ack & (rec_ack_i == seq_q);

  tcp_timer #(.MAX(TW_CYCLES)) u_tw_timer (
    .clk(clk), .reset(reset),
    .load_i((state_d == TIME_WAIT) && (state_q != TIME_WAIT)),
    .expire_o(tw_exp)
  );

`ifdef TCP_RETX_EN
  tcp_timer #(.MAX(RTO_CYCLES)) u_rto_timer (
    .clk(clk), .reset(reset),
    .load_i(is_rto_state(state_d) && (state_d != state_q)),
    .expire_o(rto_exp)
  );
`else
  assign rto_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    ack_d   = ack_q;
    pend_d  = 1'b0;
    if (cancel_v_i || rec_rst) begin
      state_d = CLOSED;
    end else begin
      case (state_q)
        CLOSED: if (open_v_i) begin
          state_d = SYN_EMIT; seq_d = open_seq_i; ack_d = '0;
        end
        SYN_EMIT: if (sent_v_i) begin state_d = SYN_SENT; seq_d = seq_q + SEQ_W'(1); end
        SYN_SENT: begin
          if (rec_syn && ack_ok) begin
            state_d = ACK_EMIT; ack_d = rec_seq_i + SEQ_W'(1);
          end else if (rto_exp) begin
            state_d = SYN_EMIT; seq_d = seq_q - SEQ_W'(1);
          end
        end
        ACK_EMIT: if (sent_v_i) state_d = EST;
        EST: begin
          // A transmit and a receive in the same cycle both take effect.
          pend_d = pend_q;
          if (sent_v_i) begin seq_d = seq_q + SEQ_W'(send_size_i); pend_d = 1'b0; end
          if (rec_fin) begin
            state_d = CW_EMIT; ack_d = ack_q + SEQ_W'(1); pend_d = 1'b0;
          end else if (close_v_i) begin
            state_d = FIN1_EMIT; pend_d = 1'b0;
          end else if (rec_v_i) begin
            if (rec_seq_i != ack_q) pend_d = 1'b1;
            else if (rec_size_i != '0) begin
              ack_d = ack_q + SEQ_W'(rec_size_i); pend_d = 1'b1;
            end
          end
        end
        FIN1_EMIT: if (sent_v_i) begin state_d = FIN_WAIT_1; seq_d = seq_q + SEQ_W'(1); end
        FIN_WAIT_1: begin
          if (ack_ok && rec_fin) begin
            state_d = TW_EMIT; ack_d = ack_q + SEQ_W'(1);
          end else if (ack_ok) begin
            state_d = FIN_WAIT_2;
          end else if (rto_exp) begin
            state_d = FIN1_EMIT; seq_d = seq_q - SEQ_W'(1);
          end
        end
        FIN_WAIT_2: if (rec_fin) begin state_d = TW_EMIT; ack_d = ack_q + SEQ_W'(1); end
        TW_EMIT:    if (sent_v_i) state_d = TIME_WAIT;
        TIME_WAIT:  if (tw_exp) state_d = CLOSED;
        CW_EMIT:    if (sent_v_i) state_d = CLOSE_WAIT;
        CLOSE_WAIT: if (close_v_i) state_d = LA_EMIT;
        LA_EMIT:    if (sent_v_i) begin state_d = LAST_ACK; seq_d = seq_q + SEQ_W'(1); end
        LAST_ACK: begin
          if (ack_ok) state_d = CLOSED;
          else if (rto_exp) begin state_d = LA_EMIT; seq_d = seq_q - SEQ_W'(1); end
        end
        default: state_d = CLOSED;
      endcase
    end
  end

  // Status and request flags are decoded from the next state so they line up
  // with state_q / seq_q / ack_q after every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLOSED;
      seq_q      <= '0;
      ack_q      <= '0;
      pend_q     <= 1'b0;
      req_v_q    <= 1'b0;
      req_flag_q <= '0;
      valid_q    <= 1'b0;
      est_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      ack_q      <= ack_d;
      pend_q     <= pend_d;
      req_v_q    <= req_v_f(state_d, pend_d);
      req_flag_q <= req_flag_f(state_d, pend_d);
      valid_q    <= (state_d != CLOSED);
      est_q      <= (state_d == EST);
    end
  end

  assign req_v_o    = req_v_q;
  assign req_flag_o = req_flag_q;
  assign req_seq_o  = seq_q;
  assign req_ack_o  = ack_q;
  assign valid_o    = valid_q;
  assign est_o      = est_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_tcp_conn_fsm.sv
// Directed bench for tcp_conn_fsm: open, data, active/passive close, abort,
// sequence wrap and (with TCP_RETX_EN) SYN retransmission.
module tb_tcp_conn_fsm;
  import tcp_pkg::*;

  localparam int SEQ_W  = 32;
  localparam int SIZE_W = 16;
  localparam int TW     = 4;
  localparam int RTO    = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  tcp_conn_fsm_if #(.SEQ_W(SEQ_W), .SIZE_W(SIZE_W)) bus ();

  tcp_conn_fsm #(.SEQ_W(SEQ_W), .SIZE_W(SIZE_W), .TW_CYCLES(TW), .RTO_CYCLES(RTO)) dut (
    .clk(clk), .reset(reset),
    .open_v_i(bus.open_v), .open_seq_i(bus.open_seq),
    .close_v_i(bus.close_v), .cancel_v_i(bus.cancel_v),
    .rec_v_i(bus.rec_v), .rec_size_i(bus.rec_size), .rec_seq_i(bus.rec_seq),
    .rec_ack_i(bus.rec_ack), .rec_flag_i(bus.rec_flag),
    .sent_v_i(bus.sent_v), .send_size_i(bus.send_size),
    .req_v_o(bus.req_v), .req_flag_o(bus.req_flag), .req_seq_o(bus.req_seq),
    .req_ack_o(bus.req_ack), .valid_o(bus.valid), .est_o(bus.est), .state_o(bus.state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: each pulse is sampled by exactly one clock edge
  task automatic do_open(input logic [SEQ_W-1:0] s);
    bus.open_v = 1'b1; bus.open_seq = s; step(); bus.open_v = 1'b0;
  endtask

  task automatic do_close();
    bus.close_v = 1'b1; step(); bus.close_v = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel_v = 1'b1; step(); bus.cancel_v = 1'b0;
  endtask

  task automatic do_sent(input logic [SIZE_W-1:0] sz);
    bus.sent_v = 1'b1; bus.send_size = sz; step(); bus.sent_v = 1'b0; bus.send_size = '0;
  endtask

  task automatic do_rec(input logic [7:0] fl, input logic [SEQ_W-1:0] s,
                        input logic [SEQ_W-1:0] a, input logic [SIZE_W-1:0] sz);
    bus.rec_v = 1'b1; bus.rec_flag = fl; bus.rec_seq = s; bus.rec_ack = a; bus.rec_size = sz;
    step();
    bus.rec_v = 1'b0; bus.rec_flag = '0; bus.rec_size = '0;
  endtask

  task automatic establish(input logic [SEQ_W-1:0] iss, input logic [SEQ_W-1:0] irs);
    do_open(iss);
    do_sent('0);
    do_rec(8'h12, irs, iss + 32'd1, '0);
    do_sent('0);
    check("est_up", bus.est, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0;
    bus.open_v = 0; bus.open_seq = '0; bus.close_v = 0; bus.cancel_v = 0;
    bus.rec_v = 0; bus.rec_size = '0; bus.rec_seq = '0; bus.rec_ack = '0; bus.rec_flag = '0;
    bus.sent_v = 0; bus.send_size = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    check("rst_state", bus.state, 4'd0);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_est",   bus.est,   1'b0);
    check("rst_req_v", bus.req_v, 1'b0);
    check("rst_seq",   bus.req_seq, 32'h0);
    check("rst_ack",   bus.req_ack, 32'h0);

    // close outside EST is ignored
    do_close();
    check("close_ignored", bus.state, 4'd0);

    // active open
    do_open(32'h100);
    check("syn_state", bus.state, 4'd1);
    check("syn_req_v", bus.req_v, 1'b1);
    check("syn_flag",  bus.req_flag, 8'h02);
    check("syn_seq",   bus.req_seq, 32'h100);
    step();
    check("syn_hold",  bus.req_v, 1'b1);
    do_sent('0);
    check("syn_sent_state", bus.state, 4'd2);
    check("syn_sent_seq",   bus.req_seq, 32'h101);
    check("syn_sent_req_v", bus.req_v, 1'b0);
    do_rec(8'h12, 32'h500, 32'h101, '0);
    check("ackemit_state", bus.state, 4'd3);
    check("ackemit_ack",   bus.req_ack, 32'h501);
    check("ackemit_flag",  bus.req_flag, 8'h10);
    check("ackemit_req_v", bus.req_v, 1'b1);
    do_sent('0);
    check("est_o",     bus.est, 1'b1);
    check("est_valid", bus.valid, 1'b1);
    check("est_req_v", bus.req_v, 1'b0);

    // data path
    do_rec(8'h18, 32'h501, 32'h101, 16'd20);
    check("data_ack",   bus.req_ack, 32'h515);
    check("data_req_v", bus.req_v, 1'b1);
    check("data_flag",  bus.req_flag, 8'h10);
    do_sent(16'd8);
    check("data_seq",     bus.req_seq, 32'h109);
    check("data_req_v0",  bus.req_v, 1'b0);
    do_rec(8'h10, 32'h600, 32'h109, 16'd5);
    check("ooo_ack",   bus.req_ack, 32'h515);
    check("ooo_req_v", bus.req_v, 1'b1);
    do_sent('0);
    check("ooo_cleared", bus.req_v, 1'b0);
    // simultaneous transmit and receive
    bus.sent_v = 1'b1; bus.send_size = 16'd4;
    do_rec(8'h10, 32'h515, 32'h109, 16'd3);
    bus.sent_v = 1'b0; bus.send_size = '0;
    check("both_seq",   bus.req_seq, 32'h10D);
    check("both_ack",   bus.req_ack, 32'h518);
    check("both_req_v", bus.req_v, 1'b1);
    do_sent('0);

    // active close
    do_close();
    check("fin1_state", bus.state, 4'd5);
    check("fin1_flag",  bus.req_flag, 8'h11);
    do_sent('0);
    check("fw1_state", bus.state, 4'd6);
    check("fw1_seq",   bus.req_seq, 32'h10E);
    do_rec(8'h10, 32'h518, 32'h10E, '0);
    check("fw2_state", bus.state, 4'd7);
    do_rec(8'h11, 32'h518, 32'h10E, '0);
    check("twemit_state", bus.state, 4'd8);
    check("twemit_ack",   bus.req_ack, 32'h519);
    check("twemit_flag",  bus.req_flag, 8'h10);
    do_sent('0);
    check("tw_state", bus.state, 4'd9);
    for (int i = 1; i < TW; i++) begin
      step();
      check("tw_valid_held", bus.valid, 1'b1);
    end
    step();
    check("tw_valid_drop", bus.valid, 1'b0);
    check("tw_closed",     bus.state, 4'd0);

    // passive close
    establish(32'h200, 32'h700);
    do_rec(8'h11, 32'h701, 32'h201, '0);
    check("cw_state", bus.state, 4'd10);
    check("cw_ack",   bus.req_ack, 32'h702);
    check("cw_flag",  bus.req_flag, 8'h10);
    do_sent('0);
    check("cwait_state", bus.state, 4'd11);
    check("cwait_req_v", bus.req_v, 1'b0);
    do_close();
    check("la_state", bus.state, 4'd12);
    check("la_flag",  bus.req_flag, 8'h11);
    do_sent('0);
    check("lack_state", bus.state, 4'd13);
    check("lack_seq",   bus.req_seq, 32'h202);
    do_rec(8'h10, 32'h702, 32'h202, '0);
    check("passive_closed", bus.state, 4'd0);
    check("passive_valid",  bus.valid, 1'b0);

    // abort by RST in FIN_WAIT_2
    establish(32'h300, 32'h800);
    do_close();
    do_sent('0);
    do_rec(8'h10, 32'h801, 32'h302, '0);
    check("rst_pre_fw2", bus.state, 4'd7);
    do_rec(8'h04, 32'h801, 32'h302, '0);
    check("rst_closed", bus.state, 4'd0);
    check("rst_req_v0", bus.req_v, 1'b0);
    check("rst_valid0", bus.valid, 1'b0);

    // sequence wrap, then cancel
    do_open(32'hFFFF_FFFF);
    check("wrap_iss", bus.req_seq, 32'hFFFF_FFFF);
    do_sent('0);
    check("wrap_seq", bus.req_seq, 32'h0000_0000);
    do_cancel();
    check("cancel_state", bus.state, 4'd0);
    check("cancel_req_v", bus.req_v, 1'b0);

    // cancel during an emit state drops the request
    do_open(32'h42);
    do_cancel();
    check("cancel_emit_state", bus.state, 4'd0);
    check("cancel_emit_req_v", bus.req_v, 1'b0);

`ifdef TCP_RETX_EN
    do_open(32'h400);
    do_sent('0);
    check("retx_wait_seq", bus.req_seq, 32'h401);
    for (int i = 1; i < RTO; i++) step();
    check("retx_still_waiting", bus.state, 4'd2);
    step();
    check("retx_state", bus.state, 4'd1);
    check("retx_seq",   bus.req_seq, 32'h400);
    check("retx_req_v", bus.req_v, 1'b1);
    check("retx_flag",  bus.req_flag, 8'h02);
    do_cancel();
`else
    // without retransmission SYN_SENT waits indefinitely
    do_open(32'h400);
    do_sent('0);
    for (int i = 0; i < RTO + 4; i++) step();
    check("no_retx_state", bus.state, 4'd2);
    check("no_retx_seq",   bus.req_seq, 32'h401);
    do_cancel();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
